avst_frame_switch: RTL and testbench

- Two-input Avalon-ST video frame switch/scheduler. It shares one 24-bit video output (feeding the padding/output stage) between two sources, e.g. TPG and live input.
- Switching happens only on frame boundaries. A frame is any control/other packets followed by one video packet.
- It decodes width and height from the forwarded control packet and presents them, with a strobe, as configuration for the downstream stage.

---
 rtl/avst_frame_switch.sv | 179 +++++++++++++++++
 tb/tb_avst_frame_switch.sv | 526 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avst_frame_switch.sv
// avst_frame_switch: shares one 24-bit Avalon-ST video output between two sinks, switching only on frame boundaries.
// Define WDOG_EN to enable the HOLD-state inter-packet watchdog (WDOG_CYCLES); otherwise wdog_flag is tied low.
module avst_frame_switch #(
   parameter bit          DROP_UNSELECTED = 1'b1,
   parameter int unsigned WDOG_CYCLES     = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [23:0] din0_data,
   input  logic        din0_valid,
   input  logic        din0_startofpacket,
   input  logic        din0_endofpacket,
   output logic        din0_ready,
   input  logic [23:0] din1_data,
   input  logic        din1_valid,
   input  logic        din1_startofpacket,
   input  logic        din1_endofpacket,
   output logic        din1_ready,
   output logic [23:0] dout_data,
   output logic        dout_valid,
   output logic        dout_startofpacket,
   output logic        dout_endofpacket,
   input  logic        dout_ready,
   output logic        active_src,
   output logic [15:0] frame_width,
   output logic [15:0] frame_height,
   output logic        cfg_valid,
   output logic        frame_done,
   output logic        wdog_flag
);

   typedef enum logic [2:0] {IDLE, HOLD, CTRL, OTHER, VIDEO} state_t;

   state_t      state;
   logic [1:0]  beat_cnt;
   logic [15:0] w_asm, h_asm, w_nxt, h_nxt;
   logic        cur, cur_valid, cur_sop, cur_eop, cur_ready;
   logic [23:0] cur_data;
   logic        fwd, acc, wdog_hit;

   always_comb begin
      cur       = (state == IDLE) ? sel : active_src;
      cur_data  = cur ? din1_data          : din0_data;
      cur_valid = cur ? din1_valid         : din0_valid;
      cur_sop   = cur ? din1_startofpacket : din0_startofpacket;
      cur_eop   = cur ? din1_endofpacket   : din0_endofpacket;
      // Between packets only SOP beats pass; anything else is swallowed to resync.
      fwd       = (state == CTRL) || (state == OTHER) || (state == VIDEO) || cur_sop;
   end

   always_comb begin
      din0_ready = 1'b0;
      din1_ready = 1'b0;
      dout_valid = 1'b0;
      cur_ready  = 1'b0;
      if (!reset) begin
         cur_ready  = fwd ? dout_ready : 1'b1;
         dout_valid = fwd && cur_valid;
         if (cur) begin
            din1_ready = cur_ready;
            din0_ready = DROP_UNSELECTED;
         end else begin
            din0_ready = cur_ready;
            din1_ready = DROP_UNSELECTED;
         end
      end
   end

   assign dout_data          = cur_data;
   assign dout_startofpacket = cur_sop;
   assign dout_endofpacket   = cur_eop;
   assign acc                = cur_valid && cur_ready;

   always_comb begin
      w_nxt = w_asm;
      h_nxt = h_asm;
      case (beat_cnt)
         2'd0: begin
            w_nxt[15:12] = cur_data[3:0];
            w_nxt[11:8]  = cur_data[11:8];
            w_nxt[7:4]   = cur_data[19:16];
         end
         2'd1: begin
            w_nxt[3:0]   = cur_data[3:0];
            h_nxt[15:12] = cur_data[11:8];
            h_nxt[11:8]  = cur_data[19:16];
         end
         2'd2: begin
            h_nxt[7:4]   = cur_data[3:0];
            h_nxt[3:0]   = cur_data[11:8];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         active_src   <= 1'b0;
         beat_cnt     <= '0;
         w_asm        <= '0;
         h_asm        <= '0;
         frame_width  <= '0;
         frame_height <= '0;
         cfg_valid    <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         cfg_valid  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE, HOLD: begin
               if (state == IDLE) active_src <= sel;
               if (acc && cur_sop) begin
                  beat_cnt <= '0;
                  if (cur_data[3:0] == 4'hF) begin
                     state <= cur_eop ? HOLD : CTRL;
                  end else if (cur_data[3:0] == 4'h0) begin
                     state      <= cur_eop ? IDLE : VIDEO;
                     frame_done <= cur_eop;
                  end else begin
                     state <= cur_eop ? HOLD : OTHER;
                  end
               end else if (wdog_hit) begin
                  state <= IDLE;
               end
            end
            CTRL: begin
               if (acc) begin
                  w_asm <= w_nxt;
                  h_asm <= h_nxt;
                  if (beat_cnt != 2'd3) beat_cnt <= beat_cnt + 2'd1;
                  if (cur_eop) begin
                     state <= HOLD;
                     // beat_cnt >= 2 means this EOP beat is the third payload beat or later.
                     if (beat_cnt >= 2'd2) begin
                        frame_width  <= w_nxt;
                        frame_height <= h_nxt;
                        cfg_valid    <= 1'b1;
                     end
                  end
               end
            end
            OTHER: begin
               if (acc && cur_eop) state <= HOLD;
            end
            VIDEO: begin
               if (acc && cur_eop) begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WDOG_EN
   localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
   logic [15:0] wdog_cnt;

   assign wdog_hit = (state == HOLD) && !acc && (wdog_cnt == WDOG_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdog_cnt  <= '0;
         wdog_flag <= 1'b0;
      end else begin
         if ((state != HOLD) || acc || wdog_hit) wdog_cnt <= '0;
         else                                    wdog_cnt <= wdog_cnt + 16'd1;
         if (wdog_hit) wdog_flag <= 1'b1;
      end
   end
`else
   assign wdog_hit  = 1'b0;
   assign wdog_flag = 1'b0;
`endif

endmodule

// File: tb/tb_avst_frame_switch.sv
// Randomized self-checking bench for avst_frame_switch; frames are built from width/height values and the
// expected output stream, decoded size and pulse counts come from a packet-level model.
module tb_avst_frame_switch;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic [23:0] din0_data, din1_data;
   logic        din0_valid, din0_startofpacket, din0_endofpacket, din0_ready;
   logic        din1_valid, din1_startofpacket, din1_endofpacket, din1_ready;
   logic [23:0] dout_data;
   logic        dout_valid, dout_startofpacket, dout_endofpacket, dout_ready;
   logic        active_src, cfg_valid, frame_done, wdog_flag;
   logic [15:0] frame_width, frame_height;

   logic        s_din0_ready, s_din1_ready, s_dout_valid, s_dout_sop, s_dout_eop;
   logic [23:0] s_dout_data;
   logic        s_active_src, s_cfg_valid, s_frame_done, s_wdog_flag;
   logic [15:0] s_frame_width, s_frame_height;

   int checks = 0, failures = 0;
   int cfg_cnt = 0, done_cnt = 0;
   bit rand_ready = 0, chk_din1 = 0;

   typedef struct packed {logic sop; logic eop; logic [23:0] data;} beat_t;
   typedef struct packed {logic keep; beat_t b;} tx_t;

   beat_t       exp_q[$], got_q[$];
   tx_t         tx_q[$];
   logic [15:0] exp_w = '0, exp_h = '0;
   int          exp_cfg = 0, exp_done = 0;

   always #5 clk = ~clk;

   avst_frame_switch #(.DROP_UNSELECTED(1'b1), .WDOG_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .sel(sel),
      .din0_data(din0_data), .din0_valid(din0_valid), .din0_startofpacket(din0_startofpacket),
      .din0_endofpacket(din0_endofpacket), .din0_ready(din0_ready),
      .din1_data(din1_data), .din1_valid(din1_valid), .din1_startofpacket(din1_startofpacket),
      .din1_endofpacket(din1_endofpacket), .din1_ready(din1_ready),
      .dout_data(dout_data), .dout_valid(dout_valid), .dout_startofpacket(dout_startofpacket),
      .dout_endofpacket(dout_endofpacket), .dout_ready(dout_ready),
      .active_src(active_src), .frame_width(frame_width), .frame_height(frame_height),
      .cfg_valid(cfg_valid), .frame_done(frame_done), .wdog_flag(wdog_flag));

   avst_frame_switch #(.DROP_UNSELECTED(1'b0), .WDOG_CYCLES(16)) dut_stall (
      .clk(clk), .reset(reset), .sel(sel),
      .din0_data(din0_data), .din0_valid(din0_valid), .din0_startofpacket(din0_startofpacket),
      .din0_endofpacket(din0_endofpacket), .din0_ready(s_din0_ready),
      .din1_data(din1_data), .din1_valid(din1_valid), .din1_startofpacket(din1_startofpacket),
      .din1_endofpacket(din1_endofpacket), .din1_ready(s_din1_ready),
      .dout_data(s_dout_data), .dout_valid(s_dout_valid), .dout_startofpacket(s_dout_sop),
      .dout_endofpacket(s_dout_eop), .dout_ready(dout_ready),
      .active_src(s_active_src), .frame_width(s_frame_width), .frame_height(s_frame_height),
      .cfg_valid(s_cfg_valid), .frame_done(s_frame_done), .wdog_flag(s_wdog_flag));

   // Inputs change on negedge; everything is sampled 2 time units later.
   always @(negedge clk) begin
      #2;
      if (reset === 1'b0) begin
         if (dout_valid && dout_ready)
            got_q.push_back(beat_t'{dout_startofpacket, dout_endofpacket, dout_data});
         if (cfg_valid)  cfg_cnt++;
         if (frame_done) done_cnt++;
      end
   end

   always @(negedge clk) if (rand_ready) dout_ready = ($urandom_range(0, 3) != 0);

   always @(negedge clk) begin
      #3;
      if (chk_din1) begin
         checks++;
         if (din1_ready !== 1'b1 || s_din1_ready !== 1'b0) begin
            failures++;
            $display("FAIL unsel_ready got=%b/%b exp=1/0", din1_ready, s_din1_ready);
         end
      end
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL global_timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   function automatic logic [23:0] rnd24();
      return 24'($urandom);
   endfunction

   function automatic void add(logic keep, logic sop, logic eop, logic [23:0] d);
      tx_t t;
      t.keep = keep;
      t.b    = beat_t'{sop, eop, d};
      tx_q.push_back(t);
   endfunction

   // Control packet: SOP nibble F, then width/height nibbles scattered over three payload beats.
   function automatic void add_ctrl(logic [15:0] w, logic [15:0] h, int extra, bit full);
      logic [23:0] d;
      d = rnd24(); d[3:0] = 4'hF;
      add(1'b1, 1'b1, 1'b0, d);
      if (!full) begin
         add(1'b1, 1'b0, 1'b1, rnd24());
         return;
      end
      d = rnd24(); d[3:0] = w[15:12]; d[11:8] = w[11:8];  d[19:16] = w[7:4];
      add(1'b1, 1'b0, 1'b0, d);
      d = rnd24(); d[3:0] = w[3:0];   d[11:8] = h[15:12]; d[19:16] = h[11:8];
      add(1'b1, 1'b0, 1'b0, d);
      d = rnd24(); d[3:0] = h[7:4];   d[11:8] = h[3:0];
      add(1'b1, 1'b0, extra == 0, d);
      for (int i = 0; i < extra; i++) add(1'b1, 1'b0, i == extra - 1, rnd24());
      exp_w = w; exp_h = h; exp_cfg++;
   endfunction

   function automatic void add_video(int len);
      logic [23:0] d;
      d = rnd24(); d[3:0] = 4'h0;
      add(1'b1, 1'b1, len == 1, d);
      for (int i = 1; i < len; i++) add(1'b1, 1'b0, i == len - 1, rnd24());
      exp_done++;
   endfunction

   function automatic void add_other(int len);
      logic [23:0] d;
      d = rnd24(); d[3:0] = 4'($urandom_range(1, 14));
      add(1'b1, 1'b1, len == 1, d);
      for (int i = 1; i < len; i++) add(1'b1, 1'b0, i == len - 1, rnd24());
   endfunction

   function automatic void add_stray(int n);
      for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'($urandom_range(0, 1)), rnd24());
   endfunction

   function automatic int first_diff();
      int n;
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
      if (got_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   function automatic void clear_model();
      got_q.delete(); exp_q.delete(); tx_q.delete();
      cfg_cnt = 0; done_cnt = 0; exp_cfg = 0; exp_done = 0;
   endfunction

   task automatic idle_src(input bit src);
      if (src) begin din1_valid = 1'b0; din1_startofpacket = 1'b0; din1_endofpacket = 1'b0; end
      else     begin din0_valid = 1'b0; din0_startofpacket = 1'b0; din0_endofpacket = 1'b0; end
   endtask

   // Called on a negedge; holds the beat until the sink's ready is seen high, returns on a negedge.
   task automatic send(input bit src, input beat_t b);
      int unsigned n;
      logic r;
      n = 0;
      if (src) begin din1_valid = 1'b1; din1_data = b.data; din1_startofpacket = b.sop; din1_endofpacket = b.eop; end
      else     begin din0_valid = 1'b1; din0_data = b.data; din0_startofpacket = b.sop; din0_endofpacket = b.eop; end
      forever begin
         #1;
         r = src ? din1_ready : din0_ready;
         @(negedge clk);
         if (r === 1'b1) break;
         n++;
         if (n > 500) begin
            checks++; failures++;
            $display("FAIL send_timeout src=%0d ready=%b exp=1", src, r);
            break;
         end
      end
      idle_src(src);
   endtask

   task automatic send_all(input bit src, input int max_gap);
      tx_t t;
      while (tx_q.size() > 0) begin
         t = tx_q.pop_front();
         repeat ($urandom_range(0, max_gap)) @(negedge clk);
         if (t.keep) exp_q.push_back(t.b);
         send(src, t.b);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; sel = 1'b0; dout_ready = 1'b1;
      din0_valid = 1'b1; din0_startofpacket = 1'b1; din0_endofpacket = 1'b0; din0_data = 24'h00000F;
      din1_valid = 1'b1; din1_startofpacket = 1'b1; din1_endofpacket = 1'b0; din1_data = 24'h000000;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({din0_ready, din1_ready, dout_valid, s_din0_ready, s_din1_ready, s_dout_valid} !== 6'b0) begin
         failures++;
         $display("FAIL reset_handshake got=%b exp=000000",
                  {din0_ready, din1_ready, dout_valid, s_din0_ready, s_din1_ready, s_dout_valid});
      end
      checks++;
      if ({active_src, cfg_valid, frame_done, wdog_flag} !== 4'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000", {active_src, cfg_valid, frame_done, wdog_flag});
      end
      checks++;
      if ({frame_width, frame_height} !== 32'h0) begin
         failures++;
         $display("FAIL reset_size got=%h exp=00000000", {frame_width, frame_height});
      end
      idle_src(0); idle_src(1);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      int d;
      clear_model();
      rand_ready = 0; dout_ready = 1'b1; sel = 1'b0;
      din1_valid = 1'b1; din1_startofpacket = 1'b1; din1_data = 24'hABCDE0;
      chk_din1 = 1;
      add(1'b1, 1'b1, 1'b0, 24'h00000F);
      add(1'b1, 1'b0, 1'b0, 24'h080700);
      add(1'b1, 1'b0, 1'b0, 24'h040000);
      add(1'b1, 1'b0, 1'b1, 24'h030803);
      add(1'b1, 1'b1, 1'b0, 24'h123450);
      add(1'b1, 1'b0, 1'b0, 24'hAAAAAA);
      add(1'b1, 1'b0, 1'b0, 24'h555555);
      add(1'b1, 1'b0, 1'b1, 24'h0F0F0F);
      send_all(0, 1);
      repeat (4) @(negedge clk);
      chk_din1 = 0;
      idle_src(1);
      exp_w = 16'h0780; exp_h = 16'h0438;
      checks++; d = first_diff();
      if (d >= 0) begin
         failures++;
         $display("FAIL basic_stream idx=%0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
      end
      checks++;
      if (frame_width !== 16'h0780 || frame_height !== 16'h0438) begin
         failures++;
         $display("FAIL basic_size got=%h/%h exp=0780/0438", frame_width, frame_height);
      end
      checks++;
      if (cfg_cnt != 1 || done_cnt != 1) begin
         failures++;
         $display("FAIL basic_pulses got cfg=%0d done=%0d exp=1/1", cfg_cnt, done_cnt);
      end
   endtask

   task automatic test_async_reset();
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({frame_width, frame_height, active_src} !== 33'h0) begin
         failures++;
         $display("FAIL async_reset got=%h exp=0", {frame_width, frame_height, active_src});
      end
      @(negedge clk);
      reset = 1'b0;
      exp_w = '0; exp_h = '0;
      @(negedge clk);
   endtask

   task automatic test_switch();
      tx_t t;
      int d, i;
      clear_model();
      rand_ready = 1; sel = 1'b0;
      add_ctrl(16'($urandom), 16'($urandom), 0, 1);
      send_all(0, 2);
      add_video(8);
      i = 0;
      while (tx_q.size() > 0) begin
         t = tx_q.pop_front();
         exp_q.push_back(t.b);
         send(0, t.b);
         if (i == 2) sel = 1'b1;
         if (tx_q.size() > 0) begin
            checks++;
            if (active_src !== 1'b0) begin
               failures++;
               $display("FAIL switch_locked beat=%0d got=%b exp=0", i, active_src);
            end
         end
         i++;
      end
      checks++;
      if (active_src !== 1'b0) begin
         failures++;
         $display("FAIL switch_at_eop got=%b exp=0", active_src);
      end
      @(negedge clk);
      checks++;
      if (active_src !== 1'b1) begin
         failures++;
         $display("FAIL switch_after_eop got=%b exp=1", active_src);
      end
      add_ctrl(16'($urandom), 16'($urandom), 1, 1);
      add_video(5);
      send_all(1, 2);
      repeat (4) @(negedge clk);
      checks++; d = first_diff();
      if (d >= 0) begin
         failures++;
         $display("FAIL switch_stream idx=%0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
      end
      checks++;
      if (frame_width !== exp_w || frame_height !== exp_h || cfg_cnt != exp_cfg || done_cnt != exp_done) begin
         failures++;
         $display("FAIL switch_cfg got=%h/%h cfg=%0d done=%0d exp=%h/%h cfg=%0d done=%0d",
                  frame_width, frame_height, cfg_cnt, done_cnt, exp_w, exp_h, exp_cfg, exp_done);
      end
   endtask

   task automatic test_backpressure();
      logic [23:0] data [100];
      int idx, c, d;
      clear_model();
      rand_ready = 0; sel = 1'b0;
      for (int k = 0; k < 100; k++) data[k] = rnd24();
      data[0][3:0] = 4'h0;
      idx = 0; c = 0;
      while (idx < 100 && c < 1000) begin
         dout_ready = !(c >= 40 && c < 45);
         din0_valid = 1'b1; din0_data = data[idx];
         din0_startofpacket = (idx == 0); din0_endofpacket = (idx == 99);
         #1;
         checks++;
         if (din0_ready !== dout_ready) begin
            failures++;
            $display("FAIL bp_ready cycle=%0d got=%b exp=%b", c, din0_ready, dout_ready);
         end
         @(negedge clk);
         if (dout_ready) begin
            exp_q.push_back(beat_t'{idx == 0, idx == 99, data[idx]});
            idx++;
         end
         c++;
      end
      idle_src(0);
      dout_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++; d = first_diff();
      if (d >= 0) begin
         failures++;
         $display("FAIL bp_stream idx=%0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
      end
      checks++;
      if (done_cnt != 1) begin
         failures++;
         $display("FAIL bp_done got=%0d exp=1", done_cnt);
      end
   endtask

   task automatic test_stall();
      sel = 1'b0; dout_ready = 1'b1;
      din1_valid = 1'b1; din1_startofpacket = 1'b1; din1_endofpacket = 1'b1; din1_data = 24'h000000;
      for (int k = 0; k < 20; k++) begin
         #1;
         checks++;
         if (s_din1_ready !== 1'b0 || s_dout_valid !== 1'b0 || din1_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_unsel cycle=%0d got=%b/%b/%b exp=0/0/1", k, s_din1_ready, s_dout_valid, din1_ready);
         end
         @(negedge clk);
      end
      idle_src(1);
      @(negedge clk);
   endtask

   task automatic test_stray();
      int d;
      clear_model();
      rand_ready = 0; dout_ready = 1'b1; sel = 1'b0;
      for (int k = 0; k < 3; k++) begin
         din0_valid = 1'b1; din0_startofpacket = 1'b0; din0_endofpacket = k[0]; din0_data = rnd24();
         #1;
         checks++;
         if (din0_ready !== 1'b1 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL stray_drop k=%0d got=%b/%b exp=1/0", k, din0_ready, dout_valid);
         end
         @(negedge clk);
      end
      idle_src(0);
      add_ctrl(16'($urandom), 16'($urandom), 0, 1);
      add_video(3);
      send_all(0, 1);
      repeat (3) @(negedge clk);
      checks++; d = first_diff();
      if (d >= 0) begin
         failures++;
         $display("FAIL stray_stream idx=%0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
      end
      checks++;
      if (frame_width !== exp_w || frame_height !== exp_h) begin
         failures++;
         $display("FAIL stray_size got=%h/%h exp=%h/%h", frame_width, frame_height, exp_w, exp_h);
      end
   endtask

   task automatic test_random();
      bit src;
      int d;
      clear_model();
      rand_ready = 1;
      for (int f = 0; f < 10; f++) begin
         src = 1'($urandom_range(0, 1));
         sel = src;
         add_stray($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) add_other($urandom_range(1, 3));
         case ($urandom_range(0, 2))
            1: add_ctrl(16'($urandom), 16'($urandom), $urandom_range(0, 2), 1);
            2: add_ctrl(16'($urandom), 16'($urandom), 0, 0);
            default: ;
         endcase
         add_stray($urandom_range(0, 1));
         add_video($urandom_range(1, 6));
         send_all(src, 2);
      end
      repeat (4) @(negedge clk);
      checks++; d = first_diff();
      if (d >= 0) begin
         failures++;
         $display("FAIL rand_stream idx=%0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
      end
      checks++;
      if (frame_width !== exp_w || frame_height !== exp_h) begin
         failures++;
         $display("FAIL rand_size got=%h/%h exp=%h/%h", frame_width, frame_height, exp_w, exp_h);
      end
      checks++;
      if (cfg_cnt != exp_cfg || done_cnt != exp_done) begin
         failures++;
         $display("FAIL rand_pulses got cfg=%0d done=%0d exp cfg=%0d done=%0d", cfg_cnt, done_cnt, exp_cfg, exp_done);
      end
   endtask

`ifdef WDOG_EN
   task automatic test_watchdog();
      clear_model();
      rand_ready = 0; dout_ready = 1'b1; sel = 1'b0;
      add_ctrl(16'($urandom), 16'($urandom), 0, 1);
      send_all(0, 0);
      sel = 1'b1;
      repeat (15) @(negedge clk);
      checks++;
      if (wdog_flag !== 1'b0) begin
         failures++;
         $display("FAIL wdog_early got=%b exp=0", wdog_flag);
      end
      @(negedge clk);
      checks++;
      if (wdog_flag !== 1'b1 || active_src !== 1'b0) begin
         failures++;
         $display("FAIL wdog_fire got flag=%b src=%b exp=1/0", wdog_flag, active_src);
      end
      @(negedge clk);
      checks++;
      if (active_src !== 1'b1) begin
         failures++;
         $display("FAIL wdog_resample got=%b exp=1", active_src);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (wdog_flag !== 1'b0) begin
         failures++;
         $display("FAIL wdog_reset got=%b exp=0", wdog_flag);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask
`else
   task automatic test_hold();
      int d;
      clear_model();
      rand_ready = 0; dout_ready = 1'b1; sel = 1'b0;
      add_ctrl(16'($urandom), 16'($urandom), 0, 1);
      send_all(0, 0);
      sel = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (wdog_flag !== 1'b0 || active_src !== 1'b0) begin
         failures++;
         $display("FAIL hold_wait got flag=%b src=%b exp=0/0", wdog_flag, active_src);
      end
      add_video(4);
      send_all(0, 1);
      repeat (3) @(negedge clk);
      checks++; d = first_diff();
      if (d >= 0) begin
         failures++;
         $display("FAIL hold_stream idx=%0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
      end
      checks++;
      if (done_cnt != 1 || active_src !== 1'b1) begin
         failures++;
         $display("FAIL hold_release got done=%0d src=%b exp=1/1", done_cnt, active_src);
      end
   endtask
`endif

   initial begin
      din0_data = '0; din1_data = '0;
      test_reset();
      test_basic();
      test_async_reset();
      test_switch();
      test_backpressure();
      test_stall();
      test_stray();
      test_random();
`ifdef WDOG_EN
      test_watchdog();
`else
      test_hold();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
